// File: rtl/readout_pkg.sv
// Shared types and width helpers for the column readout sequencer and its counter.
// Pure declarations: no logic, no latency, no flow control.
package readout_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    VALID  = 2'd2,
    DONE   = 2'd3
  } readout_state_t;

  // Column select width; a 2-column row still needs one select bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Settle counter width; it briefly holds settle_cycles on the capture edge.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/settle_counter.sv
// Loadable up/down counter with a terminal-value flag for settling delays.
// Load/count take effect on the next edge; terminal is combinational from the count; no flow control.
module settle_counter
  import readout_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] count,
  output logic         terminal
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = up ? (count_q + W'(1)) : (count_q - W'(1));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == term_val);

endmodule

// File: rtl/readout_sequencer.sv
// Steps the column mux select, waits settle_cycles, then registers the CDS result as one pixel.
// First pixel valid settle_cycles+1 edges after start; pixel held stable until pix_ready.
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int mux_width     = 2,
  parameter int bus_width     = 8,
  parameter int settle_cycles = 1,
  localparam int SW = sel_width(mux_width),
  localparam int CW = cnt_width(settle_cycles)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [bus_width-1:0] cds_in,
  output logic [SW-1:0]        select,
  output logic [bus_width-1:0] pix_data,
  output logic [SW-1:0]        pix_col,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 pix_last,
  output logic                 busy,
  output logic                 row_done
);

  localparam logic [SW-1:0] LAST_COL = SW'(mux_width - 1);
  localparam logic [CW-1:0] TERM_CNT = CW'(settle_cycles - 1);

  readout_state_t state_q, state_d;

  logic [SW-1:0]        select_q, select_d;
  logic [SW-1:0]        pix_col_q, pix_col_d;
  logic [bus_width-1:0] pix_data_q, pix_data_d;
  logic                 pix_last_q, pix_last_d;

  logic [CW-1:0] settle_cnt;
  logic          settle_done;
  logic          cnt_load;
  logic          cnt_en;
  logic          abort_row;
  logic          capture;
  logic          xfer;

  // Counter sits at zero outside SETTLE, so every entry into SETTLE starts a fresh wait.
  settle_counter #(
    .W (CW)
  ) u_settle_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val ('0),
    .en       (cnt_en),
    .up       (1'b1),
    .term_val (TERM_CNT),
    .count    (settle_cnt),
    .terminal (settle_done)
  );

  assign abort_row = abort && (state_q != IDLE);
  assign capture   = (state_q == SETTLE) && settle_done && !abort;
  assign xfer      = (state_q == VALID) && pix_ready && !abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_row) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start && !abort) state_d = SETTLE;
        SETTLE:  if (settle_done) state_d = VALID;
        VALID:   if (pix_ready) state_d = pix_last_q ? DONE : SETTLE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    row_done  = (state_q == DONE);
    pix_valid = (state_q == VALID);
    cnt_en    = (state_q == SETTLE);
    cnt_load  = (state_q != SETTLE);
  end

  // Capture register and column stepping; abort outranks a same-edge transfer.
  always_comb begin
    select_d   = select_q;
    pix_col_d  = pix_col_q;
    pix_data_d = pix_data_q;
    pix_last_d = pix_last_q;
    if (abort_row) begin
      select_d   = '0;
      pix_last_d = 1'b0;
    end else if (capture) begin
      pix_data_d = cds_in;
      pix_col_d  = select_q;
      pix_last_d = (select_q == LAST_COL);
    end else if (xfer) begin
      select_d   = pix_last_q ? '0 : (select_q + SW'(1));
      pix_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      select_q   <= '0;
      pix_col_q  <= '0;
      pix_data_q <= '0;
      pix_last_q <= 1'b0;
    end else begin
      select_q   <= select_d;
      pix_col_q  <= pix_col_d;
      pix_data_q <= pix_data_d;
      pix_last_q <= pix_last_d;
    end
  end

  assign select   = select_q;
  assign pix_col  = pix_col_q;
  assign pix_data = pix_data_q;
  assign pix_last = pix_last_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench: two sequencers (settle 1 and settle 3) each fed by a behavioural mux/mux/sub chain.
module tb_readout_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [7:0] in1 [2] = '{8'd85, 8'd200};
  logic [7:0] in2 [2] = '{8'd157, 8'd255};

  logic       start_a, abort_a, ready_a;
  logic [0:0] sel_a, col_a;
  logic [7:0] cds_a, data_a;
  logic       valid_a, last_a, busy_a, done_a;

  logic       start_b, abort_b, ready_b;
  logic [0:0] sel_b, col_b;
  logic [7:0] cds_b, data_b;
  logic       valid_b, last_b, busy_b, done_b;

  assign cds_a = in1[sel_a] - in2[sel_a];
  assign cds_b = in1[sel_b] - in2[sel_b];

  readout_sequencer #(
    .mux_width     (2),
    .bus_width     (8),
    .settle_cycles (1)
  ) dut_a (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start_a),
    .abort     (abort_a),
    .cds_in    (cds_a),
    .select    (sel_a),
    .pix_data  (data_a),
    .pix_col   (col_a),
    .pix_valid (valid_a),
    .pix_ready (ready_a),
    .pix_last  (last_a),
    .busy      (busy_a),
    .row_done  (done_a)
  );

  readout_sequencer #(
    .mux_width     (2),
    .bus_width     (8),
    .settle_cycles (3)
  ) dut_b (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start_b),
    .abort     (abort_b),
    .cds_in    (cds_b),
    .select    (sel_b),
    .pix_data  (data_b),
    .pix_col   (col_b),
    .pix_valid (valid_b),
    .pix_ready (ready_b),
    .pix_last  (last_b),
    .busy      (busy_b),
    .row_done  (done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid_a(input int max, output int n);
    n = 0;
    while (!valid_a && n < max) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n;
  int edges;
  int low;

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0;
    #3;
    check("rst_busy",  busy_a,  0);
    check("rst_valid", valid_a, 0);
    check("rst_data",  data_a,  0);
    check("rst_col",   col_a,   0);
    check("rst_sel",   sel_a,   0);
    check("rst_last",  last_a,  0);
    check("rst_done",  done_a,  0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic row, downstream always ready
    ready_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("t1_busy",    busy_a,  1);
    check("t1_novalid", valid_a, 0);
    tick();
    check("t1_v0",    valid_a, 1);
    check("t1_d0",    data_a,  184);
    check("t1_c0",    col_a,   0);
    check("t1_l0",    last_a,  0);
    tick();
    check("t1_gap",   valid_a, 0);
    check("t1_sel1",  sel_a,   1);
    tick();
    check("t1_v1",    valid_a, 1);
    check("t1_d1",    data_a,  201);
    check("t1_c1",    col_a,   1);
    check("t1_l1",    last_a,  1);
    tick();
    check("t1_done",      done_a,  1);
    check("t1_done_busy", busy_a,  1);
    check("t1_done_sel",  sel_a,   0);
    check("t1_done_nv",   valid_a, 0);
    tick();
    check("t1_done_off", done_a, 0);
    check("t1_idle",     busy_a, 0);
    check("t1_idle_sel", sel_a,  0);

    // Backpressure on column 0
    ready_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_valid_a(10, n);
    check("t2_valid", valid_a, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_v", valid_a, 1);
      check("t2_hold_d", data_a,  184);
      check("t2_hold_c", col_a,   0);
      check("t2_hold_s", sel_a,   0);
    end
    ready_a = 1'b1;
    tick();
    check("t2_rel_sel", sel_a, 1);
    wait_valid_a(10, n);
    check("t2_d1", data_a, 201);
    check("t2_l1", last_a, 1);
    tick();
    check("t2_done", done_a, 1);
    tick();

    // Latency and inter-column gap with settle_cycles=3
    ready_b = 1'b1;
    start_b = 1'b1; tick(); start_b = 1'b0;
    edges = 1;
    while (!valid_b && edges < 20) begin
      tick();
      edges++;
    end
    check("t3_latency", edges,  4);
    check("t3_d0",      data_b, 184);
    check("t3_c0",      col_b,  0);
    low = 0;
    tick();
    while (!valid_b && low < 20) begin
      low++;
      tick();
    end
    check("t3_gap", low,    3);
    check("t3_d1",  data_b, 201);
    check("t3_c1",  col_b,  1);
    tick();
    check("t3_done", done_b, 1);
    tick();
    check("t3_idle", busy_b, 0);

    // Abort while column 1 is backpressured, on the same edge as ready
    ready_a = 1'b1;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_valid_a(10, n);
    tick();
    check("t4_sel1", sel_a, 1);
    ready_a = 1'b0;
    wait_valid_a(10, n);
    check("t4_c1", col_a, 1);
    tick();
    check("t4_hold", valid_a, 1);
    abort_a = 1'b1; ready_a = 1'b1;
    tick();
    abort_a = 1'b0; ready_a = 1'b0;
    check("t4_busy",  busy_a,  0);
    check("t4_sel",   sel_a,   0);
    check("t4_valid", valid_a, 0);
    check("t4_last",  last_a,  0);
    check("t4_done",  done_a,  0);
    tick();
    check("t4_done2", done_a, 0);
    check("t4_busy2", busy_a, 0);

    // start and abort together in IDLE: abort wins
    start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    check("t4_sa_idle", busy_a, 0);

    // start while busy is ignored (mid-SETTLE and in DONE)
    ready_a = 1'b1;
    start_a = 1'b1; tick();
    tick();
    start_a = 1'b0;
    check("t5_v0", valid_a, 1);
    check("t5_c0", col_a,   0);
    tick();
    tick();
    check("t5_c1", col_a, 1);
    start_a = 1'b1;
    tick();
    check("t5_done", done_a, 1);
    tick();
    start_a = 1'b0;
    check("t5_idle",  busy_a, 0);
    tick();
    check("t5_still", busy_a, 0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_valid_a(10, n);
    check("t5_fresh_c", col_a,  0);
    check("t5_fresh_d", data_a, 184);
    tick();
    wait_valid_a(10, n);
    tick();
    check("t5_fresh_done", done_a, 1);
    tick();

    // Asynchronous reset between edges while a pixel is held
    ready_a = 1'b0;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_valid_a(10, n);
    check("t6_pre_v", valid_a, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_valid", valid_a, 0);
    check("t6_data",  data_a,  0);
    check("t6_sel",   sel_a,   0);
    check("t6_busy",  busy_a,  0);
    @(negedge clk);
    rst_n   = 1'b1;
    ready_a = 1'b1;
    tick();
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_valid_a(10, n);
    check("t6_d0", data_a, 184);
    tick();
    wait_valid_a(10, n);
    check("t6_d1", data_a, 201);
    check("t6_l1", last_a, 1);
    tick();
    check("t6_done", done_a, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
- Column readout sequencer directly downstream of the column CDS datapath (two column muxes feeding the subtractor).
- Drives the shared mux `select`, waits for the combinational mux→sub path to settle, then registers the subtractor result.
- Streams one pixel per column over a valid/ready interface toward the output/serializer stage.
- One row is read per `start` pulse.

Parameters:
- mux_width, 2, number of columns per row (must be ≥ 2).
- bus_width, 8, pixel/CDS data width.
- settle_cycles, 1, clock cycles to wait after `select` changes before capture (must be ≥ 1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin reading one row; sampled in IDLE only.
- abort  input  1  synchronous abort of the current row.
- cds_in  input  bus_width  subtractor output for the currently selected column.
- select  output  $clog2(mux_width)  column select to both column muxes.
- pix_data  output  bus_width  registered CDS value.
- pix_col  output  $clog2(mux_width)  column index of pix_data.
- pix_valid  output  1  pix_data/pix_col/pix_last valid.
- pix_ready  input  1  downstream accepts the pixel.
- pix_last  output  1  pixel is the last column of the row.
- busy  output  1  high whenever state != IDLE.
- row_done  output  1  one-cycle pulse after the last pixel transfers.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, select=0, pix_data=0, pix_col=0, pix_valid=0, pix_last=0, busy=0, row_done=0, settle counter=0.
- States: IDLE, SETTLE, VALID, DONE.
- IDLE: select held at 0. On start=1 at an edge → SETTLE, settle counter=0, busy=1.
- SETTLE: counter increments each edge.
  - At the edge where counter == settle_cycles-1, capture cds_in → pix_data and select → pix_col.
  - Same edge: pix_last = (select == mux_width-1), pix_valid=1, → VALID.
- Latency: pix_valid rises settle_cycles+1 edges after the start edge. With settle_cycles=1, valid is high after the 2nd edge.
- VALID: pix_data, pix_col and pix_last are held stable while pix_valid=1 and pix_ready=0. A transfer occurs at an edge with pix_valid=1 and pix_ready=1.
  - Transfer, non-last: pix_valid=0, select increments by 1, → SETTLE with counter=0.
  - Transfer, last: pix_valid=0, select=0, → DONE.
- DONE: row_done=1 for exactly this one cycle, busy=1, → IDLE on the next edge.
- start while busy (including DONE) is ignored; there is no queuing.
- abort=1 at any edge in a non-IDLE state → IDLE, select=0, pix_valid=0, pix_last=0, no row_done. abort has priority over a simultaneous transfer. abort in IDLE has no effect.
- If start and abort are both 1 in IDLE, stay in IDLE (abort wins).
- select never exceeds mux_width-1. No wrap to 0 other than after the last pixel or on abort.
- cds_in is passed through unmodified, modulo 2^bus_width, exactly as the subtractor produces it. No clamping or sign handling in this block.
- Reset asserted mid-row returns all outputs to reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package `readout_pkg`:
  - state enum `readout_state_t` {IDLE, SETTLE, VALID, DONE}.
  - helper constant/function for the select width, $clog2(mux_width).
- Natural sub-module `settle_counter`: a loadable down/up counter with a terminal flag, reused by later stages that need ADC settling.
- Everything else (FSM, capture register) stays in readout_sequencer.

Test Plan:
- Testbench instantiates readout_sequencer with mux_width=2, bus_width=8, settle_cycles=1, connected to the existing mux/mux/sub chain.
- Column data: in1={85,200}, in2={157,255}.
- Tests:
  1. Basic row, pix_ready=1 constantly, single start pulse → two pixels: (pix_data=184, pix_col=0, pix_last=0), then (pix_data=201, pix_col=1, pix_last=1). row_done pulses once, 1 cycle after the 2nd transfer. busy=0 afterwards; select=0.
  2. Backpressure: pix_ready=0 for 5 cycles after the first valid → pix_data stays 184, pix_col stays 0, select stays 0 for all 5 cycles. On release, the sequence continues to 201.
  3. Latency with settle_cycles=3 → pix_valid rises exactly 4 edges after the start edge. Between columns, pix_valid is low for exactly 3 cycles.
  4. Abort during backpressure of column 1 (abort=1 and pix_ready=1 on the same edge) → no transfer counted. Next cycle: IDLE, select=0, pix_valid=0, no row_done.
  5. start pulsed while busy (mid-SETTLE and in DONE) → ignored. A start after busy=0 produces a fresh row beginning at pix_col=0.
  6. Asynchronous reset asserted between edges while pix_valid=1 → pix_valid, pix_data, select and busy go to 0 before the next edge. Releasing reset then starting a row yields 184, then 201.
